// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-path definitions: FSM state codes and widths common to fetch, decode and ROM.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_STEP_DEF = 2;
  localparam logic [15:0] HALT_OPCODE_DEF = 16'hFFFF;

  // Sequencer FSM encoding; kept as plain constants so older decode blocks can reuse the codes.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Saturating increment for the 16-bit fetch counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_ir_slot.sv
// One-entry instruction register between fetch and decode, with load, flush and valid/ready drain.
// Latency: a loaded word is visible on ir_* the cycle after load_en.
// Backpressure: holds contents while ir_valid && !ir_ready; flush drops the entry regardless.
module fetch_ir_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_instr,
  output logic [DATA_W-1:0] ir_pc,
  output logic              ir_valid
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  // Next-entry selection: flush beats load, load beats a plain consume.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else if (valid_q && ir_ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ir_instr = instr_q;
  assign ir_pc    = pc_q;
  assign ir_valid = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM and fills the IR slot.
// Latency: a word appears on ir_* one cycle after its PC is on pc_out.
// Backpressure: a held, unconsumed IR stalls the PC and counter; redirect flushes even when stalled.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter int                PC_STEP     = PC_STEP_DEF,
  parameter int                ROM_DEPTH   = 15,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(HALT_OPCODE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] pc_out,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] ir_instr,
  output logic [DATA_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       fetch_count
);

  localparam logic [DATA_W-1:0] ROM_LIMIT = DATA_W'(ROM_DEPTH);
  localparam logic [DATA_W-1:0] STEP      = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] ALIGN_MSK = ~{{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [15:0]       count_q, count_d;

  logic ir_load;
  logic ir_flush;
  logic slot_free;
  logic pc_in_range;

  // The slot can take a new word when empty or when decode is taking the current one.
  assign slot_free   = !ir_valid || ir_ready;
  assign pc_in_range = (pc_q >> 1) < ROM_LIMIT;

  // FSM, PC, fault and counter next-state: redirect > capture/fault in RUN; start in IDLE/HALTED.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    count_d  = count_q;
    ir_load  = 1'b0;
    ir_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d     = redirect_pc & ALIGN_MSK;
          ir_flush = 1'b1;
        end else if (slot_free) begin
          if (pc_in_range) begin
            ir_load = 1'b1;
            pc_d    = pc_q + STEP;
            count_d = sat_inc16(count_q);
            if (instr_in == HALT_OPCODE) begin
              state_d = ST_HALTED;
            end
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALTED;
          end
        end
      end
      default: begin
        // IDLE and HALTED: only start matters, and it overrides any redirect.
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = RESET_PC;
          fault_d  = 1'b0;
          count_d  = '0;
          ir_flush = 1'b1;
        end
      end
    endcase
  end

  // Control state registers with asynchronous reset to the idle program start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  fetch_ir_slot #(
    .DATA_W (DATA_W)
  ) u_ir_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (ir_load),
    .flush    (ir_flush),
    .instr_in (instr_in),
    .pc_in    (pc_q),
    .ir_ready (ir_ready),
    .ir_instr (ir_instr),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid)
  );

  assign pc_out      = pc_q;
  assign busy        = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALTED);
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule
